// File: rtl/wb_regfile_if.sv
// Writeback/decode bus for wb_regfile: W-stage commit inputs, D-stage read ports
// and the forwarded writeback result.
interface wb_regfile_if #(
   parameter int unsigned AW = 5
);
   logic          RegWriteW;
   logic          MemtoRegW;
   logic          hilowriteW;
   logic [2:0]    loadtypeW;
   logic [31:0]   aluoutW;
   logic [31:0]   readdataW;
   logic [AW-1:0] writeregW;
   logic [31:0]   hidataW;
   logic [31:0]   lodataW;
   logic [AW-1:0] raddr1D;
   logic [AW-1:0] raddr2D;
   logic [31:0]   rdata1D;
   logic [31:0]   rdata2D;
   logic [31:0]   hiD;
   logic [31:0]   loD;
   logic [31:0]   resultW;

   // Pipeline side: drives W-stage controls and D-stage addresses.
   modport master (
      output RegWriteW, MemtoRegW, hilowriteW, loadtypeW, aluoutW, readdataW,
      output writeregW, hidataW, lodataW, raddr1D, raddr2D,
      input  rdata1D, rdata2D, hiD, loD, resultW
   );

   // Register file side.
   modport slave (
      input  RegWriteW, MemtoRegW, hilowriteW, loadtypeW, aluoutW, readdataW,
      input  writeregW, hidataW, lodataW, raddr1D, raddr2D,
      output rdata1D, rdata2D, hiD, loD, resultW
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and GPR/HI/LO storage. Forms the writeback value (ALU result or
// extended load data), commits it, and serves the decode-stage read ports.
// Optional macro WB_REGFILE_BYPASS_EN: same-cycle write-through onto the read ports.
module wb_regfile #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5
) (
   input logic         clk,
   input logic         reset,
   wb_regfile_if.slave bus
);

   logic [31:0] gpr [NREG];
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] load_ext;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic        gpr_we;

   // Load lane selection and extension; unknown load types pass the word through.
   always_comb begin
      byte_val = bus.readdataW[8*bus.aluoutW[1:0] +: 8];
      half_val = bus.aluoutW[1] ? bus.readdataW[31:16] : bus.readdataW[15:0];
      load_ext = bus.readdataW;
      case (bus.loadtypeW)
         3'b001:  load_ext = {{24{byte_val[7]}}, byte_val};
         3'b010:  load_ext = {24'h0, byte_val};
         3'b011:  load_ext = {{16{half_val[15]}}, half_val};
         3'b100:  load_ext = {16'h0, half_val};
         default: load_ext = bus.readdataW;
      endcase
   end

   assign bus.resultW = bus.MemtoRegW ? load_ext : bus.aluoutW;
   assign gpr_we      = bus.RegWriteW && (bus.writeregW != '0);

   // Storage update; reset wins over any write presented in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) begin
            gpr[i] <= '0;
         end
         hi <= '0;
         lo <= '0;
      end else begin
         if (gpr_we) begin
            gpr[bus.writeregW] <= bus.resultW;
         end
         if (bus.hilowriteW) begin
            hi <= bus.hidataW;
            lo <= bus.lodataW;
         end
      end
   end

   // Read ports; register 0 always reads zero, even when a bypass would match.
   always_comb begin
      bus.rdata1D = (bus.raddr1D == '0) ? '0 : gpr[bus.raddr1D];
      bus.rdata2D = (bus.raddr2D == '0) ? '0 : gpr[bus.raddr2D];
      bus.hiD     = hi;
      bus.loD     = lo;
`ifdef WB_REGFILE_BYPASS_EN
      if (gpr_we && (bus.raddr1D == bus.writeregW)) begin
         bus.rdata1D = bus.resultW;
      end
      if (gpr_we && (bus.raddr2D == bus.writeregW)) begin
         bus.rdata2D = bus.resultW;
      end
      if (bus.hilowriteW) begin
         bus.hiD = bus.hidataW;
         bus.loD = bus.lodataW;
      end
`else
      // Without write-through, the hazard unit forwards W to D.
`endif
   end

endmodule
